// File: rtl/data_island_scheduler.sv
// data_island_scheduler
//   Places one HDMI data island inside the horizontal blanking of a line:
//   4 control pixels, 8-pixel preamble, 2-pixel leading guard, up to
//   MAX_PACKETS 32-pixel packets, 2-pixel trailing guard, leaving
//   TAIL_RESERVE blanking pixels free after the trailing guard.
//   All outputs are registered. The next state is computed one pixel ahead,
//   so each output lands on the pixel offset it belongs to. Offset 0 is the
//   pixel that carries line_start.
// Ports
//   clk_pixel            in   pixel clock
//   reset_n              in   asynchronous active-low reset
//   line_start           in   first blanking pixel of a line
//   blank_length[11:0]   in   blanking pixels, sampled with line_start
//   island_enable        in   island permission, sampled with line_start
//   data_preamble        out  preamble period
//   data_guard           out  leading/trailing guard band
//   data_island          out  packet period
//   packet_enable        out  one-pixel pulse: latch the next packet
//   packet_pixel_counter out  pixel index inside the current packet
//   packet_count[4:0]    out  packets started in the current island
module data_island_scheduler #(
  parameter int MAX_PACKETS  = 18,
  parameter int TAIL_RESERVE = 22
) (
  input  logic        clk_pixel,
  input  logic        reset_n,
  input  logic        line_start,
  input  logic [11:0] blank_length,
  input  logic        island_enable,
  output logic        data_preamble,
  output logic        data_guard,
  output logic        data_island,
  output logic        packet_enable,
  output logic [4:0]  packet_pixel_counter,
  output logic [4:0]  packet_count
);

  // Shortest blanking that still fits one packet plus the tail reserve.
  localparam logic [13:0] MIN_BLANK = 14'(48 + TAIL_RESERVE);
  localparam logic [4:0]  MAX_PK    = 5'(MAX_PACKETS);

  typedef enum logic [2:0] {
    IDLE,
    LEAD_CTRL,
    PREAMBLE,
    LEAD_GUARD,
    PACKET,
    TRAIL_GUARD
  } state_t;

  state_t      state_r, state_s;
  logic [4:0]  cnt_r, cnt_s;       // offset in lead-in, pixel in packet, cycle in trail
  logic [11:0] blank_r, blank_s;   // blanking length latched for this line
  logic        more_r, more_s;     // another packet follows the current one
  logic [4:0]  count_s;
  logic        enable_s;
  logic [13:0] need_s;             // blanking needed to start one more packet

  // After packet_count packets, one more fits when the blanking reaches
  // 48 + TAIL_RESERVE + 32 * packet_count.
  assign need_s = MIN_BLANK + {4'b0000, packet_count, 5'b00000};

  // Next-state logic; the computed values describe the following pixel.
  always_comb begin
    state_s  = state_r;
    cnt_s    = cnt_r;
    blank_s  = blank_r;
    more_s   = more_r;
    count_s  = packet_count;
    enable_s = 1'b0;
    if (line_start) begin
      // A new line always re-evaluates, aborting any island in flight.
      blank_s = blank_length;
      more_s  = 1'b0;
      if (island_enable && ({2'b00, blank_length} >= MIN_BLANK)) begin
        state_s = LEAD_CTRL;
        cnt_s   = 5'd1;
        count_s = 5'd0;
      end else begin
        state_s = IDLE;
        cnt_s   = 5'd0;
      end
    end else begin
      case (state_r)
        IDLE: begin
          cnt_s = 5'd0;
        end
        LEAD_CTRL: begin
          cnt_s = cnt_r + 5'd1;
          if (cnt_r == 5'd3) begin
            state_s = PREAMBLE;
          end else begin
            state_s = LEAD_CTRL;
          end
        end
        PREAMBLE: begin
          cnt_s = cnt_r + 5'd1;
          if (cnt_r == 5'd11) begin
            state_s = LEAD_GUARD;
          end else begin
            state_s = PREAMBLE;
          end
        end
        LEAD_GUARD: begin
          if (cnt_r == 5'd12) begin
            // Offset 13: request the first packet.
            cnt_s    = 5'd13;
            enable_s = 1'b1;
            count_s  = packet_count + 5'd1;
          end else begin
            state_s = PACKET;
            cnt_s   = 5'd0;
          end
        end
        PACKET: begin
          cnt_s = cnt_r + 5'd1;  // wraps 31 -> 0 between packets
          if (cnt_r == 5'd30) begin
            // Decide now so packet_enable lands on the last packet pixel.
            if ((packet_count < MAX_PK) && ({2'b00, blank_r} >= need_s)) begin
              more_s   = 1'b1;
              enable_s = 1'b1;
              count_s  = packet_count + 5'd1;
            end else begin
              more_s = 1'b0;
            end
          end else if (cnt_r == 5'd31) begin
            if (more_r) begin
              state_s = PACKET;
            end else begin
              state_s = TRAIL_GUARD;
              cnt_s   = 5'd0;
            end
          end else begin
            more_s = more_r;
          end
        end
        TRAIL_GUARD: begin
          if (cnt_r == 5'd1) begin
            state_s = IDLE;
            cnt_s   = 5'd0;
          end else begin
            cnt_s = cnt_r + 5'd1;
          end
        end
        default: begin
          state_s = IDLE;
          cnt_s   = 5'd0;
        end
      endcase
    end
  end

  // State and registered outputs derived from the next state.
  always_ff @(posedge clk_pixel or negedge reset_n) begin
    if (!reset_n) begin
      state_r              <= IDLE;
      cnt_r                <= 5'd0;
      blank_r              <= 12'd0;
      more_r               <= 1'b0;
      data_preamble        <= 1'b0;
      data_guard           <= 1'b0;
      data_island          <= 1'b0;
      packet_enable        <= 1'b0;
      packet_pixel_counter <= 5'd0;
      packet_count         <= 5'd0;
    end else begin
      state_r              <= state_s;
      cnt_r                <= cnt_s;
      blank_r              <= blank_s;
      more_r               <= more_s;
      data_preamble        <= (state_s == PREAMBLE);
      data_guard           <= (state_s == LEAD_GUARD) || (state_s == TRAIL_GUARD);
      data_island          <= (state_s == PACKET);
      packet_enable        <= enable_s;
      packet_pixel_counter <= (state_s == PACKET) ? cnt_s : 5'd0;
      packet_count         <= count_s;
    end
  end

endmodule

// File: tb/tb_data_island_scheduler.sv
module tb_data_island_scheduler;

  logic        clk_pixel = 1'b0;
  logic        reset_n = 1'b0;
  logic        line_start = 1'b0;
  logic [11:0] blank_length = 12'd0;
  logic        island_enable = 1'b0;
  logic        data_preamble, data_guard, data_island, packet_enable;
  logic [4:0]  packet_pixel_counter, packet_count;

  data_island_scheduler dut (
    .clk_pixel(clk_pixel),
    .reset_n(reset_n),
    .line_start(line_start),
    .blank_length(blank_length),
    .island_enable(island_enable),
    .data_preamble(data_preamble),
    .data_guard(data_guard),
    .data_island(data_island),
    .packet_enable(packet_enable),
    .packet_pixel_counter(packet_pixel_counter),
    .packet_count(packet_count)
  );

  always #5 clk_pixel = ~clk_pixel;

  typedef struct packed {
    logic       pre;
    logic       grd;
    logic       isl;
    logic       en;
    logic [4:0] pix;
    logic [4:0] cnt;
  } exp_t;

  int checks = 0;
  int errors = 0;
  int prev_b, prev_en, prev_len, prev_pc;

  // Expected outputs at offset o (o >= 1) of a line, from the timing rules.
  function automatic exp_t model(int b, int en, int o, int pc);
    exp_t e;
    int   n;
    int   k;
    e = '0;
    e.cnt = pc[4:0];
    n = (en != 0 && b >= 70) ? (b - 70) / 32 + 1 : 0;
    if (n > 18) n = 18;
    if (n == 0) return e;
    e.pre = (o >= 4 && o <= 11);
    e.grd = (o == 12 || o == 13 || o == 14 + 32 * n || o == 15 + 32 * n);
    e.isl = (o >= 14 && o < 14 + 32 * n);
    if (e.isl) begin
      k = (o - 14) % 32;
      e.pix = k[4:0];
    end
    e.en = (o == 13) || (o >= 45 && (o - 45) % 32 == 0 && (o - 45) / 32 + 1 < n);
    if (o < 13) begin
      k = 0;
    end else begin
      k = 1 + ((o >= 45) ? (o - 45) / 32 + 1 : 0);
      if (k > n) k = n;
    end
    e.cnt = k[4:0];
    return e;
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic compare(string tag, exp_t e);
    chk({tag, "_preamble"}, 32'(data_preamble), 32'(e.pre));
    chk({tag, "_guard"}, 32'(data_guard), 32'(e.grd));
    chk({tag, "_island"}, 32'(data_island), 32'(e.isl));
    chk({tag, "_pkt_en"}, 32'(packet_enable), 32'(e.en));
    chk({tag, "_pixel"}, 32'(packet_pixel_counter), 32'(e.pix));
    chk({tag, "_count"}, 32'(packet_count), 32'(e.cnt));
  endtask

  // Runs one line of len pixels; offset 0 still shows the previous line.
  task automatic run_line(int b, int en, int len);
    exp_t e;
    int   pc;
    e  = model(prev_b, prev_en, prev_len, prev_pc);
    pc = int'(e.cnt);
    for (int o = 0; o < len; o++) begin
      if (o > 0) e = model(b, en, o, pc);
      compare($sformatf("b%0d_e%0d_o%0d", b, en, o), e);
      line_start    = (o == 0);
      blank_length  = b[11:0];
      island_enable = en[0];
      @(posedge clk_pixel);
      #1;
    end
    line_start = 1'b0;
    prev_b   = b;
    prev_en  = en;
    prev_len = len;
    prev_pc  = pc;
  endtask

  initial begin
    int b;
    int len;
    exp_t e;
    prev_b = 0; prev_en = 0; prev_len = 1; prev_pc = 0;

    #12;
    compare("reset", '0);
    reset_n = 1'b1;
    @(posedge clk_pixel);
    #1;
    compare("post_reset_idle", '0);

    run_line(370, 1, 380);
    run_line(138, 1, 150);
    run_line(69, 1, 80);
    run_line(70, 1, 80);
    run_line(1000, 1, 1000);
    run_line(370, 0, 380);

    for (int i = 0; i < 8; i++) begin
      b   = int'($urandom_range(0, 1100));
      len = b + int'($urandom_range(1, 20));
      run_line(b, ($urandom_range(0, 3) != 0) ? 1 : 0, len);
    end

    // Abort: a new line_start at offset 200 of an island.
    run_line(370, 1, 200);
    run_line(138, 1, 150);

    // Asynchronous reset at offset 50 of an island.
    run_line(370, 1, 50);
    e = model(370, 1, 50, prev_pc);
    compare("pre_reset_o50", e);
    #2 reset_n = 1'b0;
    #1;
    compare("async_reset", '0);
    @(posedge clk_pixel);
    #1;
    compare("reset_held", '0);
    #2 reset_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk_pixel);
      #1;
      compare($sformatf("after_reset_%0d", i), '0);
    end
    prev_b = 0; prev_en = 0; prev_len = 1; prev_pc = 0;
    run_line(370, 1, 380);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
